contador_regressivo_mmss: RTL and testbench
===========================================

# contador_regressivo_mmss

Countdown timer for the clock's timer mode, counting MM:SS down in BCD from a loaded preset to 00:00. It decrements with cascaded BCD borrows: seconds units, then seconds tens, then minutes units, then minutes tens. It is driven by the same one-pulse-per-second tick that feeds the up-counting chain. On reaching zero it stops and raises an alarm for the display and buzzer logic.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle pulse, once per second
- load  in  1  load preset digits
- ld_min_dezena  in  3  preset minutes tens, 0-5
- ld_min_unidade  in  4  preset minutes units, 0-9
- ld_seg_dezena  in  3  preset seconds tens, 0-5
- ld_seg_unidade  in  4  preset seconds units, 0-9
- start  in  1  start or resume counting
- pause  in  1  suspend counting
- min_dezena  out  3  current minutes tens
- min_unidade  out  4  current minutes units
- seg_dezena  out  3  current seconds tens
- seg_unidade  out  4  current seconds units
- running  out  1  high while in RUN
- zero  out  1  high when all four digits equal 0
- expirou  out  1  one-cycle pulse when the count reaches 00:00
- alarme  out  1  sticky alarm, high in DONE

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- Reset values: all digits 0, running=0, expirou=0, alarme=0. zero=1 as a consequence of the digits.
- Input priority within one cycle: rst > load > pause > start > tick.
- load, valid in any state:
  - Copies the ld_* digits into the counters.
  - Clamps out-of-range values: units above 9 become 9; tens above 5 become 5.
  - Goes to IDLE and clears alarme.
  - A start in the same cycle is ignored.
- IDLE:
  - start with zero=0 goes to RUN.
  - start with zero=1 stays in IDLE; no expirou, no alarme.
  - tick is ignored.
- RUN:
  - tick decrements the count by one second.
  - pause goes to PAUSED. If pause and tick arrive in the same cycle, the tick is dropped and there is no decrement.
  - start has no effect.
- PAUSED:
  - start goes back to RUN.
  - tick is ignored; the digits hold.
- DONE:
  - Digits hold at 00:00 and alarme=1.
  - start, pause and tick are ignored.
  - Only load or rst leave DONE.
- Decrement rules:
  - seg_unidade: 0 becomes 9 and borrows into seg_dezena; otherwise subtract 1.
  - seg_dezena, on borrow: 0 becomes 5 and borrows into min_unidade; otherwise subtract 1.
  - min_unidade, on borrow: 0 becomes 9 and borrows into min_dezena; otherwise subtract 1.
  - min_dezena, on borrow: subtract 1. It never wraps below 0, because RUN is never entered at 00:00.
- Expiry: when a tick in RUN produces 00:00, the next state is DONE, expirou pulses for exactly one cycle and alarme is set.
- All digits stay valid BCD at every moment. Tens never exceed 5; units never exceed 9.

## Timing
- All outputs are registered or derived only from registers. There is no combinational path from any input to any output.
- Tick to digit update: 1 cycle. Digits change on the clk edge that samples tick.
- Expiry: expirou, alarme=1, running=0 and the 00:00 digits all become visible on the same edge.
- expirou lasts exactly one cycle, then returns to 0 even if tick continues.
- start to running=1: 1 cycle.
- pause to running=0: 1 cycle.
- load: the new digits and state IDLE are visible 1 cycle after load is sampled.
- Reset mid-operation: on the edge sampling rst=1, all outputs take their reset values regardless of state.
- A long start level in PAUSED or IDLE is equivalent to a single start; no edge detection is required.
- tick is assumed to be a single-cycle pulse. Consecutive tick cycles in RUN decrement once per cycle.

## Test plan
- load 01:00, start, one tick → 00:59 one cycle after the tick, running=1, expirou=0.
- load 10:00, start, one tick → 09:59, with the borrow cascading through all four digits.
- load 00:02, start, two ticks:
  - after the first tick → 00:01.
  - after the second tick → 00:00, expirou high for one cycle, alarme=1, running=0.
  - three further ticks → digits stay 00:00, expirou stays 0.
- load 05:30, start, pause:
  - three ticks → 05:30 held.
  - start, then a tick → 05:29.
  - pause and tick in the same cycle → no decrement.
- load with ld_min_dezena=7, ld_min_unidade=4'hC, ld_seg_dezena=6, ld_seg_unidade=4'hF → 59:59.
- Zero preset: load 00:00, start → running stays 0, no expirou, no alarme.
- DONE recovery: from DONE, load 00:10 → alarme=0, IDLE.
- Reset mid-run: rst asserted during RUN at 03:17 → next cycle all digits 0, running=0, alarme=0, expirou=0.

Source files
------------

// File: rtl/contador_regressivo_mmss.sv
// MM:SS BCD countdown timer for the clock's timer mode.
// Counts a loaded preset down to 00:00 on each one-second tick, then latches an alarm.
module contador_regressivo_mmss (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [2:0] ld_min_dezena,
  input  logic [3:0] ld_min_unidade,
  input  logic [2:0] ld_seg_dezena,
  input  logic [3:0] ld_seg_unidade,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] min_dezena,
  output logic [3:0] min_unidade,
  output logic [2:0] seg_dezena,
  output logic [3:0] seg_unidade,
  output logic       running,
  output logic       zero,
  output logic       expirou,
  output logic       alarme
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;

  logic [2:0] min_dezena_next;
  logic [3:0] min_unidade_next;
  logic [2:0] seg_dezena_next;
  logic [3:0] seg_unidade_next;
  logic       expirou_next;

  logic [2:0] md_clamped;
  logic [3:0] mu_clamped;
  logic [2:0] sd_clamped;
  logic [3:0] su_clamped;

  logic [2:0] md_dec;
  logic [3:0] mu_dec;
  logic [2:0] sd_dec;
  logic [3:0] su_dec;
  logic       borrow_sd;
  logic       borrow_mu;
  logic       borrow_md;
  logic       dec_is_zero;

  // Out-of-range preset digits saturate so the counters always hold valid BCD.
  always_comb begin
    md_clamped = (ld_min_dezena  > 3'd5) ? 3'd5 : ld_min_dezena;
    mu_clamped = (ld_min_unidade > 4'd9) ? 4'd9 : ld_min_unidade;
    sd_clamped = (ld_seg_dezena  > 3'd5) ? 3'd5 : ld_seg_dezena;
    su_clamped = (ld_seg_unidade > 4'd9) ? 4'd9 : ld_seg_unidade;
  end

  always_comb begin
    borrow_sd = (seg_unidade == 4'd0);
    su_dec    = borrow_sd ? 4'd9 : seg_unidade - 4'd1;

    borrow_mu = borrow_sd && (seg_dezena == 3'd0);
    sd_dec    = seg_dezena;
    if (borrow_sd)
      sd_dec = (seg_dezena == 3'd0) ? 3'd5 : seg_dezena - 3'd1;

    borrow_md = borrow_mu && (min_unidade == 4'd0);
    mu_dec    = min_unidade;
    if (borrow_mu)
      mu_dec = (min_unidade == 4'd0) ? 4'd9 : min_unidade - 4'd1;

    // RUN is never entered at 00:00, so the top digit cannot underflow here.
    md_dec = min_dezena;
    if (borrow_md && (min_dezena != 3'd0))
      md_dec = min_dezena - 3'd1;

    dec_is_zero = (md_dec == 3'd0) && (mu_dec == 4'd0) &&
                  (sd_dec == 3'd0) && (su_dec == 4'd0);
  end

  always_comb begin
    state_next       = state;
    min_dezena_next  = min_dezena;
    min_unidade_next = min_unidade;
    seg_dezena_next  = seg_dezena;
    seg_unidade_next = seg_unidade;
    expirou_next     = 1'b0;

    if (load) begin
      state_next       = IDLE;
      min_dezena_next  = md_clamped;
      min_unidade_next = mu_clamped;
      seg_dezena_next  = sd_clamped;
      seg_unidade_next = su_clamped;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start && !zero)
            state_next = RUN;
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            min_dezena_next  = md_dec;
            min_unidade_next = mu_dec;
            seg_dezena_next  = sd_dec;
            seg_unidade_next = su_dec;
            if (dec_is_zero) begin
              state_next   = DONE;
              expirou_next = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause && start)
            state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      min_dezena  <= 3'd0;
      min_unidade <= 4'd0;
      seg_dezena  <= 3'd0;
      seg_unidade <= 4'd0;
      expirou     <= 1'b0;
    end else begin
      state       <= state_next;
      min_dezena  <= min_dezena_next;
      min_unidade <= min_unidade_next;
      seg_dezena  <= seg_dezena_next;
      seg_unidade <= seg_unidade_next;
      expirou     <= expirou_next;
    end
  end

  assign running = (state == RUN);
  assign alarme  = (state == DONE);
  assign zero    = (min_dezena == 3'd0) && (min_unidade == 4'd0) &&
                   (seg_dezena == 3'd0) && (seg_unidade == 4'd0);

endmodule

// File: tb/tb_contador_regressivo_mmss.sv
// Directed self-checking bench for the MM:SS countdown timer.
module tb_contador_regressivo_mmss;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       load;
  logic [2:0] ld_min_dezena;
  logic [3:0] ld_min_unidade;
  logic [2:0] ld_seg_dezena;
  logic [3:0] ld_seg_unidade;
  logic       start;
  logic       pause;
  logic [2:0] min_dezena;
  logic [3:0] min_unidade;
  logic [2:0] seg_dezena;
  logic [3:0] seg_unidade;
  logic       running;
  logic       zero;
  logic       expirou;
  logic       alarme;

  int assert_count = 0;
  int fail_count   = 0;

  contador_regressivo_mmss dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .load(load),
    .ld_min_dezena(ld_min_dezena),
    .ld_min_unidade(ld_min_unidade),
    .ld_seg_dezena(ld_seg_dezena),
    .ld_seg_unidade(ld_seg_unidade),
    .start(start),
    .pause(pause),
    .min_dezena(min_dezena),
    .min_unidade(min_unidade),
    .seg_dezena(seg_dezena),
    .seg_unidade(seg_unidade),
    .running(running),
    .zero(zero),
    .expirou(expirou),
    .alarme(alarme)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mmss(input int md, input int mu, input int sd, input int su);
    logic [13:0] v;
    v = {md[2:0], mu[3:0], sd[2:0], su[3:0]};
    return v;
  endfunction

  // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    tick  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [13:0] observed, input logic [13:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_digits(input string tag, input logic [13:0] expected);
    check_val(tag, {min_dezena, min_unidade, seg_dezena, seg_unidade}, expected);
  endtask

  task automatic check_flags(input string tag, input logic run_e, input logic exp_e, input logic alm_e);
    check_val({tag, "_running"}, {13'd0, running}, {13'd0, run_e});
    check_val({tag, "_expirou"}, {13'd0, expirou}, {13'd0, exp_e});
    check_val({tag, "_alarme"},  {13'd0, alarme},  {13'd0, alm_e});
  endtask

  task automatic do_load(input logic [2:0] md, input logic [3:0] mu, input logic [2:0] sd, input logic [3:0] su);
    load           = 1'b1;
    ld_min_dezena  = md;
    ld_min_unidade = mu;
    ld_seg_dezena  = sd;
    ld_seg_unidade = su;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    ld_min_dezena = 3'd0; ld_min_unidade = 4'd0; ld_seg_dezena = 3'd0; ld_seg_unidade = 4'd0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    check_digits("reset_digits", mmss(0, 0, 0, 0));
    check_val("reset_zero", {13'd0, zero}, 14'd1);
    check_flags("reset", 1'b0, 1'b0, 1'b0);

    // 01:00 -> 00:59
    do_load(3'd0, 4'd1, 3'd0, 4'd0);
    check_digits("load_0100", mmss(0, 1, 0, 0));
    check_val("load_0100_zero", {13'd0, zero}, 14'd0);
    do_start();
    check_val("start_running", {13'd0, running}, 14'd1);
    do_tick();
    check_digits("tick_0059", mmss(0, 0, 5, 9));
    check_flags("tick_0059", 1'b1, 1'b0, 1'b0);

    // full four-digit borrow
    do_load(3'd1, 4'd0, 3'd0, 4'd0);
    check_val("load_idle", {13'd0, running}, 14'd0);
    do_start();
    do_tick();
    check_digits("tick_0959", mmss(0, 9, 5, 9));

    // expiry
    do_load(3'd0, 4'd0, 3'd0, 4'd2);
    do_start();
    do_tick();
    check_digits("tick_0001", mmss(0, 0, 0, 1));
    check_flags("tick_0001", 1'b1, 1'b0, 1'b0);
    do_tick();
    check_digits("expire_digits", mmss(0, 0, 0, 0));
    check_flags("expire", 1'b0, 1'b1, 1'b1);
    check_val("expire_zero", {13'd0, zero}, 14'd1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_digits("done_hold", mmss(0, 0, 0, 0));
      check_flags("done_hold", 1'b0, 1'b0, 1'b1);
    end
    start = 1'b1; pause = 1'b1; tick = 1'b1;
    step();
    check_flags("done_ignore", 1'b0, 1'b0, 1'b1);

    // DONE recovery
    do_load(3'd0, 4'd0, 3'd1, 4'd0);
    check_digits("recover_digits", mmss(0, 0, 1, 0));
    check_flags("recover", 1'b0, 1'b0, 1'b0);

    // pause / resume
    do_load(3'd0, 4'd5, 3'd3, 4'd0);
    do_start();
    pause = 1'b1;
    step();
    check_val("pause_running", {13'd0, running}, 14'd0);
    for (int i = 0; i < 3; i++) do_tick();
    check_digits("paused_hold", mmss(0, 5, 3, 0));
    start = 1'b1;
    step();
    start = 1'b1;
    step();
    check_val("resume_running", {13'd0, running}, 14'd1);
    do_tick();
    check_digits("resume_0529", mmss(0, 5, 2, 9));
    pause = 1'b1; tick = 1'b1;
    step();
    check_digits("pause_tick_drop", mmss(0, 5, 2, 9));
    check_val("pause_tick_running", {13'd0, running}, 14'd0);

    // clamping
    do_load(3'd7, 4'hC, 3'd6, 4'hF);
    check_digits("clamp_5959", mmss(5, 9, 5, 9));

    // zero preset cannot start
    do_load(3'd0, 4'd0, 3'd0, 4'd0);
    do_start();
    check_flags("zero_start", 1'b0, 1'b0, 1'b0);
    do_start();
    check_flags("zero_start2", 1'b0, 1'b0, 1'b0);

    // start in the same cycle as load is ignored
    load = 1'b1; start = 1'b1;
    ld_min_dezena = 3'd0; ld_min_unidade = 4'd0; ld_seg_dezena = 3'd0; ld_seg_unidade = 4'd5;
    step();
    check_digits("load_start_digits", mmss(0, 0, 0, 5));
    check_val("load_start_running", {13'd0, running}, 14'd0);

    // reset mid-run
    do_load(3'd0, 4'd3, 3'd1, 4'd7);
    do_start();
    check_val("pre_reset_running", {13'd0, running}, 14'd1);
    rst = 1'b1; tick = 1'b1;
    step();
    check_digits("midrun_reset_digits", mmss(0, 0, 0, 0));
    check_flags("midrun_reset", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
